// File: rtl/icw_init_sequencer_if.sv
// Write-strobe and data-bus bundle from the bus control logic to the ICW init sequencer.
// The master drives strobes and data; the slave (sequencer) only samples them.
interface icw_init_sequencer_if;
    logic [7:0] internal_data_bus;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2_4;

    modport master (
        output internal_data_bus,
        output write_initial_command_word_1,
        output write_initial_command_word_2_4
    );

    modport slave (
        input internal_data_bus,
        input write_initial_command_word_1,
        input write_initial_command_word_2_4
    );
endinterface

// File: rtl/icw_init_sequencer.sv
// 8259A ICW1-ICW4 sequencer: all outputs registered, one cycle after the accepting strobe; no backpressure.
// MCS80_MODE_EN builds the MCS-80 vector registers (ICW1 D7-D5, ADI, ICW2 byte); otherwise those outputs are 0.
module icw_init_sequencer #(
    parameter logic [4:0] VECTOR_RESET  = 5'b00000,
    parameter logic [7:0] CASCADE_RESET = 8'h00
) (
    input  logic                        clock,
    input  logic                        reset,
    icw_init_sequencer_if.slave         bus,
    output logic                        init_pulse,
    output logic                        initialization_done,
    output logic                        level_or_edge_triggered_config,
    output logic                        single_or_cascade_config,
    output logic                        call_address_interval_4_or_8,
    output logic [2:0]                  mcs80_vector_address_low,
    output logic [7:0]                  mcs80_vector_address_high,
    output logic [4:0]                  interrupt_vector_address,
    output logic [7:0]                  cascade_device_config,
    output logic                        u8086_or_mcs80_config,
    output logic                        auto_eoi_config,
    output logic                        buffered_master_or_slave_config,
    output logic                        buffered_mode_config,
    output logic                        special_fully_nested_config
);
    typedef enum logic [1:0] {READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4} state_t;

    state_t      state_q, state_d;
    logic        pulse_q, pulse_d, done_q, done_d;
    logic        ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
    logic [4:0]  vector_q, vector_d;
    logic [7:0]  cascade_q, cascade_d;
    logic [4:0]  icw4_q, icw4_d;
    logic        icw1_stb, icw24_stb;
    logic [7:0]  dat;

    // ICW1 wins a same-cycle collision, so the ICW2_4 strobe is masked by it.
    assign icw1_stb  = bus.write_initial_command_word_1;
    assign icw24_stb = bus.write_initial_command_word_2_4 & ~bus.write_initial_command_word_1;
    assign dat       = bus.internal_data_bus;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= READY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (icw1_stb) begin
            state_d = WAIT_ICW2;
        end else if (icw24_stb) begin
            case (state_q)
                WAIT_ICW2: state_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
                WAIT_ICW3: state_d = ic4_q ? WAIT_ICW4 : READY;
                WAIT_ICW4: state_d = READY;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        pulse_d   = icw1_stb;
        done_d    = (state_d == READY);
        ltim_d    = ltim_q;
        sngl_d    = sngl_q;
        ic4_d     = ic4_q;
        vector_d  = vector_q;
        cascade_d = cascade_q;
        icw4_d    = icw4_q;
        if (icw1_stb) begin
            ltim_d = dat[3];
            sngl_d = dat[1];
            ic4_d  = dat[0];
            icw4_d = 5'b00000;
        end else if (icw24_stb) begin
            case (state_q)
                WAIT_ICW2: vector_d  = dat[7:3];
                WAIT_ICW3: cascade_d = dat;
                WAIT_ICW4: icw4_d    = dat[4:0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pulse_q   <= 1'b0;
            done_q    <= 1'b1;
            ltim_q    <= 1'b0;
            sngl_q    <= 1'b0;
            ic4_q     <= 1'b0;
            vector_q  <= VECTOR_RESET;
            cascade_q <= CASCADE_RESET;
            icw4_q    <= 5'b00000;
        end else begin
            pulse_q   <= pulse_d;
            done_q    <= done_d;
            ltim_q    <= ltim_d;
            sngl_q    <= sngl_d;
            ic4_q     <= ic4_d;
            vector_q  <= vector_d;
            cascade_q <= cascade_d;
            icw4_q    <= icw4_d;
        end
    end

`ifdef MCS80_MODE_EN
    logic       adi_q, adi_d;
    logic [2:0] mcs_low_q, mcs_low_d;
    logic [7:0] mcs_high_q, mcs_high_d;

    always_comb begin
        adi_d      = adi_q;
        mcs_low_d  = mcs_low_q;
        mcs_high_d = mcs_high_q;
        if (icw1_stb) begin
            adi_d     = dat[2];
            mcs_low_d = dat[7:5];
        end else if (icw24_stb && state_q == WAIT_ICW2) begin
            mcs_high_d = dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            adi_q      <= 1'b0;
            mcs_low_q  <= 3'b000;
            mcs_high_q <= 8'h00;
        end else begin
            adi_q      <= adi_d;
            mcs_low_q  <= mcs_low_d;
            mcs_high_q <= mcs_high_d;
        end
    end

    assign call_address_interval_4_or_8 = adi_q;
    assign mcs80_vector_address_low     = mcs_low_q;
    assign mcs80_vector_address_high    = mcs_high_q;
`else
    assign call_address_interval_4_or_8 = 1'b0;
    assign mcs80_vector_address_low     = 3'b000;
    assign mcs80_vector_address_high    = 8'h00;
`endif

    assign init_pulse                      = pulse_q;
    assign initialization_done             = done_q;
    assign level_or_edge_triggered_config  = ltim_q;
    assign single_or_cascade_config        = sngl_q;
    assign interrupt_vector_address        = vector_q;
    assign cascade_device_config           = cascade_q;
    assign u8086_or_mcs80_config           = icw4_q[0];
    assign auto_eoi_config                 = icw4_q[1];
    assign buffered_master_or_slave_config = icw4_q[2];
    assign buffered_mode_config            = icw4_q[3];
    assign special_fully_nested_config     = icw4_q[4];
endmodule
